// File: rtl/retire_stage.sv
// In-order retire at the ROB head: combinational commit of the oldest completed run, registered FSM/counters.
// Never stalls the ROB; blocks younger slots behind an incomplete, mispredicted or halting entry.
package retire_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int ADDR_W    = 32;
    localparam int ARCH_W    = $clog2(ARCH_REGS);
    localparam int PHYS_W    = $clog2(PHYS_REGS);

    typedef struct packed {
        logic              complete;
        logic              mispredict;
        logic              halt;
        logic [ARCH_W-1:0] arch_dest;
        logic [PHYS_W-1:0] phys_dest;
        logic [PHYS_W-1:0] prev_phys;
        logic [ADDR_W-1:0] target_pc;
    } rob_entry_t;
endpackage

module retire_stage
    import retire_pkg::*;
#(
    parameter int N         = 4,
    parameter int ROB_SZ    = 16,
    parameter int FLUSH_LAT = 2,
    parameter int CNT_W     = 32,
    localparam int IDX_W    = $clog2(ROB_SZ),
    localparam int RC_W     = $clog2(N+1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  rob_entry_t [N-1:0]            head_entries,
    input  logic [N-1:0]                  head_valids,
    input  logic [IDX_W-1:0]              head_idx,
    output logic [RC_W-1:0]               retire_count,
    output logic [N-1:0]                  map_we,
    output logic [N-1:0][ARCH_W-1:0]      map_arch,
    output logic [N-1:0][PHYS_W-1:0]      map_phys,
    output logic [N-1:0]                  free_valid,
    output logic [N-1:0][PHYS_W-1:0]      free_phys,
    output logic                          mispredict,
    output logic [IDX_W-1:0]              mispred_idx,
    output logic [ADDR_W-1:0]             redirect_pc,
    output logic                          flushing,
    output logic                          halted,
    output logic [CNT_W-1:0]              retired_insts,
    output logic [CNT_W-1:0]              stall_cycles
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam int FC_W = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;

    logic [1:0]       state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             blocked;
    logic             saw_mispred;
    logic             saw_halt;
    logic [IDX_W:0]   idx_sum;

    // Retire scan: a slot commits only if every older slot committed and was not a barrier.
    always_comb begin
        retire_count = '0;
        map_we       = '0;
        map_arch     = '0;
        map_phys     = '0;
        free_valid   = '0;
        free_phys    = '0;
        mispredict   = 1'b0;
        mispred_idx  = '0;
        redirect_pc  = '0;
        saw_mispred  = 1'b0;
        saw_halt     = 1'b0;
        idx_sum      = '0;
        blocked      = reset || (state_q != ST_RUN);
        for (int i = 0; i < N; i++) begin
            if (!blocked && head_valids[i] && head_entries[i].complete) begin
                retire_count = retire_count + RC_W'(1);
                if (head_entries[i].arch_dest != '0) begin
                    map_we[i]     = 1'b1;
                    map_arch[i]   = head_entries[i].arch_dest;
                    map_phys[i]   = head_entries[i].phys_dest;
                    free_valid[i] = 1'b1;
                    free_phys[i]  = head_entries[i].prev_phys;
                end
                if (head_entries[i].mispredict) begin
                    idx_sum = {1'b0, head_idx} + (IDX_W+1)'(i);
                    if (idx_sum >= (IDX_W+1)'(ROB_SZ)) begin
                        idx_sum = idx_sum - (IDX_W+1)'(ROB_SZ);
                    end
                    mispredict  = 1'b1;
                    mispred_idx = idx_sum[IDX_W-1:0];
                    redirect_pc = head_entries[i].target_pc;
                    saw_mispred = 1'b1;
                    blocked     = 1'b1;
                end
                if (head_entries[i].halt) begin
                    saw_halt = 1'b1;
                    blocked  = 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        retired_d   = retired_q + CNT_W'(retire_count);
        stall_d     = stall_q;
        if (state_q == ST_RUN && head_valids[0] && retire_count == '0) begin
            stall_d = stall_q + CNT_W'(1);
        end
        case (state_q)
            ST_RUN: begin
                if (saw_halt) begin
                    state_d = ST_HALTED;
                end else if (saw_mispred) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FC_W'(FLUSH_LAT - 1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            retired_q   <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            retired_q   <= retired_d;
            stall_q     <= stall_d;
        end
    end

    assign flushing      = !reset && (state_q == ST_FLUSH);
    assign halted        = !reset && (state_q == ST_HALTED);
    assign retired_insts = retired_q;
    assign stall_cycles  = stall_q;

endmodule
